// File: rtl/store_buffer_if.sv
// Bus bundle between the core data port, the backing RAM and the store buffer.
// The buffer takes the slave view; whatever drives the core side and models the RAM is the master.
interface store_buffer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              MEM_write;
    logic [ADDR_W-1:0] MEM_addr;
    logic [DATA_W-1:0] MEM_wdata;
    logic [DATA_W-1:0] MEM_rdata;
    logic [ADDR_W-1:0] bk_raddr;
    logic [DATA_W-1:0] bk_rdata;
    logic              bk_wreq;
    logic [ADDR_W-1:0] bk_waddr;
    logic [DATA_W-1:0] bk_wdata;
    logic              bk_wack;
    logic              sb_full;
    logic              sb_empty;
    logic              sb_overrun;

    modport slave (
        input  MEM_write, MEM_addr, MEM_wdata, bk_rdata, bk_wack,
        output MEM_rdata, bk_raddr, bk_wreq, bk_waddr, bk_wdata, sb_full, sb_empty, sb_overrun
    );

    modport master (
        output MEM_write, MEM_addr, MEM_wdata, bk_rdata, bk_wack,
        input  MEM_rdata, bk_raddr, bk_wreq, bk_waddr, bk_wdata, sb_full, sb_empty, sb_overrun
    );
endinterface

// File: rtl/store_buffer.sv
// Write-posting FIFO between the core data port and a slow handshaked RAM write port,
// with youngest-match load forwarding from entries that have not yet drained.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthC = (PtrW + 1)'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PtrW-1:0]   head_q, tail_q;
    logic [PtrW:0]     count_q;
    logic              overrun_q;

    logic              push, pop, is_full;
    logic [PtrW-1:0]   fwd_idx;
    logic [DATA_W-1:0] fwd_data;

    assign is_full = (count_q == DepthC);
    assign pop     = bus.bk_wreq && bus.bk_wack;
    // A pop frees the head slot on the same edge, so a store at full still fits.
    assign push    = bus.MEM_write && !rst && (!is_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.MEM_write && is_full && !pop) overrun_q <= 1'b1;
        end
    end

    // Entry storage needs no reset; validity is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= bus.MEM_addr;
            data_q[tail_q] <= bus.MEM_wdata;
        end
    end

    // Walk oldest to youngest so the last hit, closest to tail, wins.
    always_comb begin
        fwd_data = bus.bk_rdata;
        fwd_idx  = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PtrW'(i);
            if (((PtrW + 1)'(i) < count_q) &&
                (addr_q[fwd_idx][ADDR_W-1:2] == bus.MEM_addr[ADDR_W-1:2])) begin
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign bus.MEM_rdata  = fwd_data;
    assign bus.bk_raddr   = bus.MEM_addr;
    assign bus.bk_wreq    = (count_q != '0);
    assign bus.bk_waddr   = addr_q[head_q];
    assign bus.bk_wdata   = data_q[head_q];
    assign bus.sb_full    = is_full;
    assign bus.sb_empty   = (count_q == '0);
    assign bus.sb_overrun = overrun_q;
endmodule
